// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            data access. Data goes first, then fetch. The pipeline is held
//            with stall__o until every pending access has completed. Both
//            results are then reported together in one DONE cycle.
// Ports    : clock__i, reset_n__i   clock / async active-low reset
//            ifReq__i, ifAddr__i    fetch request and address
//            ifData__o, ifValid__o  fetched word and completion pulse
//            dRead__i, dWrite__i    data read / write request (both = write)
//            dAddr__i, dWData__i    data address and write data
//            dRData__o, dValid__o   read data and completion pulse
//            stall__o               pipeline hold
//            memReq__o, memWe__o    memory request / write enable (registered)
//            memAddr__o, memWData__o memory address / write data (registered)
//            memRData__i, memAck__i memory read data and one-cycle ack
//            timeout__o             sticky: an access exceeded MAX_WAIT
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clock__i,
    input  logic              reset_n__i,
    input  logic              ifReq__i,
    input  logic [ADDR_W-1:0] ifAddr__i,
    output logic [DATA_W-1:0] ifData__o,
    output logic              ifValid__o,
    input  logic              dRead__i,
    input  logic              dWrite__i,
    input  logic [ADDR_W-1:0] dAddr__i,
    input  logic [DATA_W-1:0] dWData__i,
    output logic [DATA_W-1:0] dRData__o,
    output logic              dValid__o,
    output logic              stall__o,
    output logic              memReq__o,
    output logic              memWe__o,
    output logic [ADDR_W-1:0] memAddr__o,
    output logic [DATA_W-1:0] memWData__o,
    input  logic [DATA_W-1:0] memRData__i,
    input  logic              memAck__i,
    output logic              timeout__o
);

    localparam int              CNT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] c_MAX_WAIT = CNT_W'(MAX_WAIT);
    localparam logic            c_TMO_EN   = (MAX_WAIT > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_pendIf;
    logic                r_pendD;
    logic                r_pendWr;
    logic [ADDR_W-1:0]   r_ifAddr;
    logic [DATA_W-1:0]   r_ifData;
    logic [DATA_W-1:0]   r_dRData;
    logic                r_memReq;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWData;
    logic [CNT_W-1:0]    r_wait;
    logic                r_timeout;

    logic                w_anyReq;
    logic                w_dReq;
    logic                w_busy;
    logic                w_tmo;
    logic                w_finish;
    logic                w_memReq;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memWData;

    assign w_dReq   = dRead__i | dWrite__i;
    assign w_anyReq = ifReq__i | w_dReq;
    assign w_busy   = (r_state == DATA) || (r_state == INSTR);
    // An ack in the abort cycle wins, so the timeout only fires without one.
    assign w_tmo    = c_TMO_EN && (r_wait == c_MAX_WAIT) && !memAck__i;
    assign w_finish = memAck__i | w_tmo;

    // Next state plus the next values of the registered memory port.
    always_comb begin
        w_next     = r_state;
        w_memReq   = 1'b0;
        w_memWe    = 1'b0;
        w_memAddr  = r_memAddr;
        w_memWData = r_memWData;
        case (r_state)
            IDLE: begin
                if (w_dReq) begin
                    w_next     = DATA;
                    w_memReq   = 1'b1;
                    w_memWe    = dWrite__i;
                    w_memAddr  = dAddr__i;
                    w_memWData = dWData__i;
                end else if (ifReq__i) begin
                    w_next    = INSTR;
                    w_memReq  = 1'b1;
                    w_memAddr = ifAddr__i;
                end
            end
            DATA: begin
                w_memReq = 1'b1;
                w_memWe  = r_pendWr;
                if (w_finish) begin
                    if (r_pendIf) begin
                        w_next    = INSTR;
                        w_memWe   = 1'b0;
                        w_memAddr = r_ifAddr;
                    end else begin
                        w_next   = DONE;
                        w_memReq = 1'b0;
                        w_memWe  = 1'b0;
                    end
                end
            end
            INSTR: begin
                w_memReq = 1'b1;
                if (w_finish) begin
                    w_next   = DONE;
                    w_memReq = 1'b0;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            r_pendIf   <= 1'b0;
            r_pendD    <= 1'b0;
            r_pendWr   <= 1'b0;
            r_ifAddr   <= '0;
            r_ifData   <= '0;
            r_dRData   <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_wait     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_memReq   <= w_memReq;
            r_memWe    <= w_memWe;
            r_memAddr  <= w_memAddr;
            r_memWData <= w_memWData;

            if ((r_state == IDLE) && w_anyReq) begin
                r_pendIf <= ifReq__i;
                r_pendD  <= w_dReq;
                r_pendWr <= dWrite__i;
                r_ifAddr <= ifAddr__i;
            end

            // Wait counter restarts on every state change, so it is zero on
            // the first cycle of each access.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_busy) begin
                r_wait <= r_wait + 1'b1;
            end

            // An aborted read returns all-ones so the core sees a defined word.
            if ((r_state == DATA) && w_finish && !r_pendWr) begin
                r_dRData <= memAck__i ? memRData__i : '1;
            end
            if ((r_state == INSTR) && w_finish) begin
                r_ifData <= memAck__i ? memRData__i : '1;
            end

            if (w_busy && w_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Gating with the reset keeps stall low while reset is held, even if the
    // requesters still present a request.
    assign stall__o    = reset_n__i & (((r_state == IDLE) & w_anyReq) | w_busy);
    assign ifValid__o  = (r_state == DONE) & r_pendIf;
    assign dValid__o   = (r_state == DONE) & r_pendD;
    assign ifData__o   = r_ifData;
    assign dRData__o   = r_dRData;
    assign memReq__o   = r_memReq;
    assign memWe__o    = r_memWe;
    assign memAddr__o  = r_memAddr;
    assign memWData__o = r_memWData;
    assign timeout__o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Acts as the memory and
//            both requesters; a transaction-level model predicts access order,
//            returned data and the sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_ifReq, r_dRead, r_dWrite, r_memAck;
    logic [31:0] r_ifAddr, r_dAddr, r_dWData, r_memRData;
    logic [31:0] w_ifData, w_dRData, w_memAddr, w_memWData;
    logic        w_ifValid, w_dValid, w_stall, w_memReq, w_memWe, w_timeout;

    int          n_chk = 0;
    int          n_err = 0;

    logic [31:0] exp_if, exp_d;
    logic        exp_to;
    logic [31:0] mem [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clock__i    (clk),
        .reset_n__i  (rst_n),
        .ifReq__i    (r_ifReq),
        .ifAddr__i   (r_ifAddr),
        .ifData__o   (w_ifData),
        .ifValid__o  (w_ifValid),
        .dRead__i    (r_dRead),
        .dWrite__i   (r_dWrite),
        .dAddr__i    (r_dAddr),
        .dWData__i   (r_dWData),
        .dRData__o   (w_dRData),
        .dValid__o   (w_dValid),
        .stall__o    (w_stall),
        .memReq__o   (w_memReq),
        .memWe__o    (w_memWe),
        .memAddr__o  (w_memAddr),
        .memWData__o (w_memWData),
        .memRData__i (r_memRData),
        .memAck__i   (r_memAck),
        .timeout__o  (w_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // One memory access from the memory's point of view. The memory acks on
    // wait cycle 'dly'; a dly outside 0..MAX_WAIT means it never acks.
    task automatic access(input bit isd, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input int dly);
        bit acked = 1'b0;
        for (int k = 0; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            r_memAck   = 1'b0;
            r_memRData = $urandom;
            #1;
            chk("acc_memReq",  {31'b0, w_memReq}, 32'd1);
            chk("acc_memWe",   {31'b0, w_memWe}, {31'b0, we});
            chk("acc_memAddr", w_memAddr, a);
            if (we) chk("acc_memWData", w_memWData, wd);
            chk("acc_stall",   {31'b0, w_stall}, 32'd1);
            chk("acc_valids",  {30'b0, w_ifValid, w_dValid}, 32'd0);
            if (k == dly) begin
                acked      = 1'b1;
                r_memAck   = 1'b1;
                r_memRData = we ? $urandom : memval(a);
                break;
            end
        end
        if (acked) begin
            if (we)       mem[a] = wd;
            else if (isd) exp_d  = memval(a);
            else          exp_if = memval(a);
        end else begin
            exp_to = 1'b1;
            if (!we) begin
                if (isd) exp_d  = '1;
                else     exp_if = '1;
            end
        end
    endtask

    task automatic txn(input bit f, input bit rd, input bit wr,
                       input logic [31:0] fa, input logic [31:0] da,
                       input logic [31:0] wd, input int dd, input int di);
        @(negedge clk);
        r_ifReq = f; r_dRead = rd; r_dWrite = wr;
        r_ifAddr = fa; r_dAddr = da; r_dWData = wd; r_memAck = 1'b0;
        #1;
        chk("req_stall",  {31'b0, w_stall}, 32'd1);
        chk("req_memReq", {31'b0, w_memReq}, 32'd0);
        if (rd | wr) access(1'b1, wr, da, wd, dd);
        if (f)       access(1'b0, 1'b0, fa, 32'd0, di);
        @(negedge clk);
        r_memAck = 1'b0;
        #1;
        chk("done_ifValid", {31'b0, w_ifValid}, {31'b0, f});
        chk("done_dValid",  {31'b0, w_dValid}, {31'b0, (rd | wr)});
        chk("done_stall",   {31'b0, w_stall}, 32'd0);
        chk("done_memReq",  {31'b0, w_memReq}, 32'd0);
        chk("done_ifData",  w_ifData, exp_if);
        chk("done_dRData",  w_dRData, exp_d);
        chk("done_timeout", {31'b0, w_timeout}, {31'b0, exp_to});
        @(negedge clk);
        r_ifReq = 1'b0; r_dRead = 1'b0; r_dWrite = 1'b0;
        #1;
        chk("after_valids", {30'b0, w_ifValid, w_dValid}, 32'd0);
        chk("after_stall",  {31'b0, w_stall}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        r_ifReq = 1'b0; r_dRead = 1'b0; r_dWrite = 1'b0; r_memAck = 1'b0;
        r_ifAddr = '0; r_dAddr = '0; r_dWData = '0; r_memRData = '0;
        exp_if = '0; exp_d = '0; exp_to = 1'b0;
        mem[32'h100] = 32'h2002000A;
        mem[32'h40]  = 32'h00000055;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {w_memReq, w_memWe, w_stall, w_ifValid, w_dValid, w_timeout}, 32'd0);
        chk("rst_data", w_ifData | w_dRData | w_memAddr | w_memWData, 32'd0);
        rst_n = 1'b1;

        // Fetch only, immediate ack.
        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        chk("t1_ifData", w_ifData, 32'h2002000A);
        // Fetch and data read together: data first, then fetch.
        txn(1, 1, 0, 32'h104, 32'h40, 32'h0, 0, 0);
        chk("t2_dRData", w_dRData, 32'h00000055);
        // Write acked on the third wait cycle.
        txn(0, 0, 1, 32'h0, 32'h80, 32'hDEADBEEF, 2, 0);
        // Read back the written word.
        txn(0, 1, 0, 32'h0, 32'h80, 32'h0, 1, 0);
        chk("t3_readback", w_dRData, 32'hDEADBEEF);
        // Ack on the very cycle the timeout would fire.
        txn(1, 1, 0, 32'h108, 32'h44, 32'h0, MAX_WAIT, MAX_WAIT);
        chk("t6_no_timeout", {31'b0, w_timeout}, 32'd0);

        // Spurious ack while idle.
        @(negedge clk);
        r_memAck = 1'b1; r_memRData = 32'hCAFEF00D;
        @(negedge clk);
        r_memAck = 1'b0;
        #1;
        chk("idle_ack_outs", {w_memReq, w_stall, w_ifValid, w_dValid}, 32'd0);
        chk("idle_ack_dR", w_dRData, exp_d);
        @(negedge clk);
        #1;
        chk("idle_ack_outs2", {w_memReq, w_stall, w_ifValid, w_dValid}, 32'd0);
        chk("idle_ack_if", w_ifData, exp_if);

        // Read never acked: abort with all-ones and sticky timeout.
        txn(0, 1, 0, 32'h0, 32'h48, 32'h0, -1, 0);
        chk("t4_dRData", w_dRData, 32'hFFFFFFFF);
        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        chk("t4_sticky", {31'b0, w_timeout}, 32'd1);

        // Randomised traffic over a small address pool.
        for (int n = 0; n < 40; n++) begin
            bit f, rd, wr;
            f  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!(f | rd | wr)) f = 1'b1;
            txn(f, rd, wr, 32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
                $urandom, $urandom_range(0, MAX_WAIT + 1), $urandom_range(0, MAX_WAIT + 1));
        end

        // Reset in the middle of a data access.
        @(negedge clk);
        r_dRead = 1'b1; r_dAddr = 32'h4C;
        @(negedge clk);
        #1;
        chk("t5_in_data", {31'b0, w_memReq}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_if = '0; exp_d = '0; exp_to = 1'b0;
        chk("t5_rst_outs", {w_memReq, w_memWe, w_stall, w_ifValid, w_dValid, w_timeout}, 32'd0);
        chk("t5_rst_data", w_ifData | w_dRData | w_memAddr, 32'd0);
        r_dRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1);
        chk("t5_fresh_fetch", w_ifData, 32'h2002000A);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-port memory between the core's instruction-fetch and data-access requesters. Sits between the 5-stage pipeline top and a unified memory with a req/ack handshake. Serialises accesses with data priority and holds the pipeline with a stall until all pending accesses complete. Results are returned together in a single completion cycle.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_WAIT, 255, maximum cycles to wait for memAck__i per access; 0 disables the timeout

Ports:
clock__i  in  1  single clock, rising edge
reset_n__i  in  1  reset, asynchronous, active-low
ifReq__i  in  1  instruction fetch request
ifAddr__i  in  ADDR_W  fetch address (PC)
ifData__o  out  DATA_W  fetched instruction
ifValid__o  out  1  fetch result valid, one-cycle pulse
dRead__i  in  1  data read request
dWrite__i  in  1  data write request
dAddr__i  in  ADDR_W  data address
dWData__i  in  DATA_W  write data
dRData__o  out  DATA_W  read data
dValid__o  out  1  data access complete, one-cycle pulse
stall__o  out  1  pipeline hold; requesters keep inputs stable while 1
memReq__o  out  1  memory request
memWe__o  out  1  memory write enable
memAddr__o  out  ADDR_W  memory address
memWData__o  out  DATA_W  memory write data
memRData__i  in  DATA_W  memory read data, valid with memAck__i
memAck__i  in  1  memory completion, one cycle
timeout__o  out  1  sticky: an access exceeded MAX_WAIT

Behaviour:
- Reset (async, any state, mid-access included): state goes to IDLE. All outputs go to 0, including memReq__o immediately, the data registers, and timeout__o. The wait counter and pending flags clear.
- FSM states: IDLE, DATA, INSTR, DONE.
- IDLE:
  - anyReq = ifReq__i | dRead__i | dWrite__i.
  - If anyReq, latch all present requests, addresses and write data as pending.
  - Next state is DATA if a data request is present, otherwise INSTR.
- DATA:
  - memReq__o=1. memWe__o=1 if the latched request is a write (dWrite__i and dRead__i both set counts as a write).
  - memAddr__o and memWData__o come from the latched values and stay stable while memReq__o is high.
  - On memAck__i: for a read, capture memRData__i into dRData__o; for a write, dRData__o is unchanged. Then go to INSTR if a fetch is pending, otherwise DONE.
- INSTR:
  - memReq__o=1, memWe__o=0, address is the latched fetch address.
  - On memAck__i: capture memRData__i into ifData__o, then go to DONE.
- DONE:
  - ifValid__o and dValid__o each pulse for exactly this cycle, for whichever requests were pending. Then go to IDLE.
  - Requests are ignored in DONE, because the core advances on this edge.
- Handshake rules:
  - memReq__o, memWe__o, memAddr__o and memWData__o are registered.
  - memAck__i is ignored in IDLE and DONE.
  - memAck__i may arrive in the first cycle of DATA or INSTR. The memory must not ack before seeing memReq__o.
- stall__o is combinational: (IDLE & anyReq) | DATA | INSTR. It is 0 in DONE, and 0 in IDLE with no request.
- Latency:
  - Single access with ack in its first cycle: request in c0, memReq in c1, valid and stall=0 in c2.
  - Both requesters with immediate acks: DATA in c1, INSTR in c2, DONE in c3 with both valids asserted.
- Timeout:
  - A counter clears on entry to DATA or INSTR and increments each cycle without an ack.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT without an ack, the access is aborted. The destination register loads all-ones (writes do not load), timeout__o sets and stays set until reset, and the FSM proceeds as if acked.
  - Counter width is ceil(log2(MAX_WAIT+1)), minimum 1.
  - An ack arriving in the same cycle as the timeout takes priority: data is captured and timeout__o is not set.
- ifData__o and dRData__o hold their value until the next capture.

Test Plan:
1. Fetch only: ifReq=1, ifAddr=0x100, memory acks the first cycle with 0x2002000A -> stall=1 in c0 and c1, memReq=1/memWe=0/memAddr=0x100 in c1, ifValid=1 with ifData=0x2002000A and stall=0 in c2.
2. Fetch and data read together: dRead @0x40 (returns 0x55) and ifReq @0x104 -> DATA first (memAddr 0x40), then INSTR (0x104), DONE in c3 with dValid=ifValid=1 and dRData=0x55.
3. Write with a 3-cycle ack delay: dWrite @0x80 with data 0xDEADBEEF -> memWe=1 and address/data stable for all 3 cycles, dRData unchanged, dValid pulses once, stall held through the wait.
4. Timeout: MAX_WAIT=4, read never acked -> abort after 4 wait cycles, dRData=0xFFFFFFFF, dValid pulses, timeout__o=1 and stays 1 through later normal accesses.
5. Reset mid-access: reset_n low during DATA -> memReq, stall, valids and timeout go to 0 immediately (asynchronously); after release, state is IDLE and a fresh fetch completes normally.
6. Ack coinciding with timeout, and a spurious ack in IDLE -> data is captured with timeout__o=0; the IDLE ack causes no state change and no valid pulse.
